// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        StRun,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode-side controls and the IF/ID outputs.
interface fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  fault
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: squash, hold, load; otherwise a bubble is inserted.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (squash_i || !(hold_i || load_i)) begin
            // Empty slot always reads as a NOP; the pc fields keep their last value.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_i && !hold_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux and IF/ID capture.
// FETCH_BOUNDS_EN enables the out-of-range PC check with a HALT state and fault output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        load;
    logic        squash;
    logic        hold;

    if (MEM_DEPTH == 0) begin : g_depth_check
        $error("MEM_DEPTH must be nonzero");
    end

    assign pc_plus4 = pc_q + WORD_BYTES;

`ifdef FETCH_BOUNDS_EN
    fetch_state_e state_q, state_d;
    logic         in_range;

    assign in_range = {2'b00, pc_q[31:2]} < MEM_DEPTH;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        load    = 1'b0;
        squash  = 1'b0;
        hold    = 1'b0;
        if (bus.redirect_valid) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            state_d = StRun;
            squash  = 1'b1;
        end else if (state_q == StHalt) begin
            // Parked on the faulting PC until a redirect; IF/ID drains to a bubble.
            pc_d = pc_q;
        end else if (bus.stall) begin
            hold = 1'b1;
        end else if (in_range) begin
            load = 1'b1;
            pc_d = pc_plus4;
        end else begin
            state_d = StHalt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.fault = (state_q == StHalt);
`else
    always_comb begin
        pc_d   = pc_q;
        load   = 1'b0;
        squash = 1'b0;
        hold   = 1'b0;
        if (bus.redirect_valid) begin
            pc_d   = {bus.redirect_pc[31:2], 2'b00};
            squash = 1'b1;
        end else if (bus.stall) begin
            hold = 1'b1;
        end else begin
            load = 1'b1;
            pc_d = pc_plus4;
        end
    end

    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.imem_addr = pc_q;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .squash_i   (squash),
        .hold_i     (hold),
        .instr_i    (bus.imem_instr),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .valid_o    (bus.id_valid),
        .instr_o    (bus.id_instr),
        .pc_o       (bus.id_pc),
        .pc_plus4_o (bus.id_pc_plus4)
    );

endmodule
